jtag_debug_cmd_queue: RTL and testbench
=======================================

// Module: jtag_debug_cmd_queue
// PURPOSE
//  System-clock-domain command front end for the CPU JTAG debug module; next generation of the fixed 2-bit-IR/38-bit action decoder.
//  Synchronises virtual-JTAG update strobes, captures the IR and shift register, and queues commands in a small FIFO.
//  Pops commands under a valid/ready handshake and emits one-hot take_action/take_no_action pulses.
//  Sits between the TCK-domain debug shift logic and the OCI memory, break and trace control blocks.
// PARAMETERS
//  IR_W        2   IR width; decodes 2**IR_W command channels
//  DATA_W      38  shift-register / jdo width
//  ACT_BIT     34  bit index of cmd data selecting action (1) vs no-action (0)
//  FIFO_DEPTH  4   command queue depth; power of 2, >=2
//  SYNC_STAGES 2   synchroniser flops per strobe; >=2
// PORTS
//  clk             in   1           system clock
//  reset           in   1           synchronous, active-high reset
//  vs_uir          in   1           update-IR strobe, asynchronous (TCK domain)
//  vs_udr          in   1           update-DR strobe, asynchronous (TCK domain)
//  ir_in           in   IR_W        IR value, quasi-static around vs_uir
//  sr              in   DATA_W      shift register, quasi-static around vs_udr
//  cmd_ready       in   1           consumer accepts the head command
//  ovf_clr         in   1           clears the overflow flag
//  cmd_valid       out  1           FIFO non-empty
//  cmd_ir          out  IR_W        IR of the head command
//  cmd_data        out  DATA_W      data of the head command
//  jdo             out  DATA_W      data of the last popped command, registered
//  take_action     out  2**IR_W     one-cycle pulse on channel ir, cmd_data[ACT_BIT]=1
//  take_no_action  out  2**IR_W     one-cycle pulse on channel ir, cmd_data[ACT_BIT]=0
//  fifo_count      out  clog2(D)+1  current occupancy
//  overflow        out  1           sticky flag: a command was dropped
// BEHAVIOUR
//  Reset: sync chains, edge registers, ir_q, FIFO pointers and count, jdo, both pulse vectors and overflow all clear to 0.
//  Reset mid-operation discards queued commands; any pulse due on the next cycle is suppressed.
//  Sync: each strobe passes through SYNC_STAGES flops plus one history flop.
//  Event = last stage 1 and history 0; one event per rising edge, however long the strobe is held.
//  UIR event: ir_q <= ir_in.
//  UDR event: push {ir_q, sr} into the FIFO.
//    ir_q is the value held before that edge; a UIR event on the same edge updates ir_q for later pushes only.
//  sr and ir_in are sampled directly.
//    TCK logic holds them stable for at least SYNC_STAGES+2 clk cycles after the strobe rises.
//  Latency, empty FIFO: cmd_valid rises SYNC_STAGES+2 clk edges after the first edge that samples vs_udr high.
//  FIFO: circular buffer, pointers wrap modulo FIFO_DEPTH.
//    cmd_ir/cmd_data are driven directly from the head entry, first-word fall-through.
//  Pop when cmd_valid & cmd_ready.
//  Push and pop on the same edge: count unchanged; a push is accepted even when full.
//  Push when full without pop: command dropped, overflow <= 1, queue unchanged.
//  overflow stays set until ovf_clr; a set and ovf_clr on the same edge leave it set.
//  On pop, registered, visible the next cycle for exactly one cycle:
//    jdo <= cmd_data
//    take_action[cmd_ir] <= cmd_data[ACT_BIT]
//    take_no_action[cmd_ir] <= ~cmd_data[ACT_BIT]
//    all other pulse bits <= 0
//  Between pops both pulse vectors are 0 and jdo holds its value.
//  At most one bit across both pulse vectors is set on any cycle.
//  Back-to-back pops (cmd_ready held high) give back-to-back pulses, one per cycle.
//  cmd_ready while cmd_valid=0 has no effect.
// TESTING
//  1 Reset: assert reset for 3 cycles with strobes toggling -> all outputs 0, fifo_count=0.
//  2 Basic action: UIR with ir_in=2, then UDR with sr[34]=1, sr=38'h4_0000_0ABC, cmd_ready=1
//    -> one pulse take_action=4'b0100, jdo=38'h4_0000_0ABC, take_no_action=0.
//  3 Latency: SYNC_STAGES=3, UDR with cmd_ready=0 -> cmd_valid rises exactly 5 edges after first high sample.
//    Strobe held 20 cycles -> fifo_count=1.
//  4 Full: 5 UDRs with cmd_ready=0, depth 4 -> fifo_count=4, overflow=1.
//    Pops return the first 4 commands in order; ovf_clr -> overflow=0.
//  5 Simultaneous: full FIFO, UDR event on the same edge as a pop -> count stays 4, no overflow, new entry at tail.
//  6 Same-edge UIR+UDR: ir_q=1, new ir_in=3 -> queued cmd_ir=1, next UDR queued with cmd_ir=3.

Source files
------------

// File: rtl/jtag_debug_cmd_queue_if.sv
// Command handshake between the debug command queue and its consumer.
//   cmd_valid  queue -> consumer  head entry present
//   cmd_ready  consumer -> queue  consumer takes the head entry this edge
//   cmd_ir     queue -> consumer  IR channel of the head entry
//   cmd_data   queue -> consumer  shift-register data of the head entry
// master = queue side, slave = consumer side.
interface jtag_debug_cmd_queue_if #(
  parameter int IR_W   = 2,
  parameter int DATA_W = 38
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [IR_W-1:0]   cmd_ir;
  logic [DATA_W-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_ir,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ir,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/jtag_debug_cmd_queue.sv
// System-clock front end for the CPU JTAG debug module. Synchronises the
// virtual-JTAG update-IR / update-DR strobes, captures IR and shift data,
// queues commands in a small FIFO and, on each pop, emits the data on jdo_o
// plus a one-cycle one-hot take_action / take_no_action pulse.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   vs_uir_i, vs_udr_i  asynchronous update strobes from the TCK domain
//   ir_in_i, sr_i       IR value and shift register, quasi-static
//   ovf_clr_i           clears the sticky overflow flag
//   cmd_if              head-of-queue handshake (master side)
//   jdo_o               data of the last popped command
//   take_action_o       one-hot pulse, popped command had ACT_BIT set
//   take_no_action_o    one-hot pulse, popped command had ACT_BIT clear
//   fifo_count_o        queue occupancy
//   overflow_o          sticky: a command was dropped on a full queue
module jtag_debug_cmd_queue #(
  parameter int IR_W        = 2,
  parameter int DATA_W      = 38,
  parameter int ACT_BIT     = 34,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          vs_uir_i,
  input  logic                          vs_udr_i,
  input  logic [IR_W-1:0]               ir_in_i,
  input  logic [DATA_W-1:0]             sr_i,
  input  logic                          ovf_clr_i,
  jtag_debug_cmd_queue_if.master        cmd_if,
  output logic [DATA_W-1:0]             jdo_o,
  output logic [(1<<IR_W)-1:0]          take_action_o,
  output logic [(1<<IR_W)-1:0]          take_no_action_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overflow_o
);

  localparam int NCH   = 1 << IR_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = IR_W + DATA_W;

  // strobe synchronisers, history flops and registered rising-edge events
  logic [SYNC_STAGES-1:0] uir_sync_q, udr_sync_q;
  logic                   uir_hist_q, udr_hist_q;
  logic                   uir_evt_q,  udr_evt_q;

  logic [IR_W-1:0]        ir_q, ir_d;

  logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic [DATA_W-1:0]      jdo_q, jdo_d;
  logic [NCH-1:0]         act_q, act_d;
  logic [NCH-1:0]         nact_q, nact_d;
  logic                   ovf_q, ovf_d;

  logic                   full, valid, push, pop, wr_en, ovf_set;
  logic [IR_W-1:0]        head_ir;
  logic [DATA_W-1:0]      head_data;

  assign valid     = (count_q != '0);
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign head_ir   = mem_q[rd_ptr_q][ENT_W-1:DATA_W];
  assign head_data = mem_q[rd_ptr_q][DATA_W-1:0];

  assign push    = udr_evt_q;
  assign pop     = valid & cmd_if.cmd_ready;
  // a pop frees the head slot on the same edge, so a full queue still accepts
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_comb begin
    ir_d     = ir_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    jdo_d    = jdo_q;
    act_d    = '0;
    nact_d   = '0;
    ovf_d    = ovf_q;

    if (uir_evt_q) ir_d = ir_in_i;

    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (pop) begin
      jdo_d           = head_data;
      act_d[head_ir]  = head_data[ACT_BIT];
      nact_d[head_ir] = ~head_data[ACT_BIT];
    end

    // set wins over clear on the same edge
    if (ovf_set)        ovf_d = 1'b1;
    else if (ovf_clr_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      uir_sync_q <= '0;
      udr_sync_q <= '0;
      uir_hist_q <= 1'b0;
      udr_hist_q <= 1'b0;
      uir_evt_q  <= 1'b0;
      udr_evt_q  <= 1'b0;
      ir_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      jdo_q      <= '0;
      act_q      <= '0;
      nact_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir_i};
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr_i};
      uir_hist_q <= uir_sync_q[SYNC_STAGES-1];
      udr_hist_q <= udr_sync_q[SYNC_STAGES-1];
      uir_evt_q  <= uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q;
      udr_evt_q  <= udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q;
      ir_q       <= ir_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      jdo_q      <= jdo_d;
      act_q      <= act_d;
      nact_q     <= nact_d;
      ovf_q      <= ovf_d;
    end
  end

  // storage needs no reset; occupancy gates visibility of stale entries.
  // ir_q is read before its same-edge update, so a coincident UIR only
  // affects later pushes.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {ir_q, sr_i};
  end

  assign cmd_if.cmd_valid = valid;
  assign cmd_if.cmd_ir    = head_ir;
  assign cmd_if.cmd_data  = head_data;

  assign jdo_o            = jdo_q;
  assign take_action_o    = act_q;
  assign take_no_action_o = nact_q;
  assign fifo_count_o     = count_q;
  assign overflow_o       = ovf_q;

endmodule

// File: tb/tb_jtag_debug_cmd_queue.sv
module tb_jtag_debug_cmd_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vs_uir = 1'b0;
  logic        vs_udr = 1'b0;
  logic [1:0]  ir_in = '0;
  logic [37:0] sr = '0;
  logic        ovf_clr = 1'b0;
  logic [37:0] jdo;
  logic [3:0]  ta, tna;
  logic [2:0]  fifo_count;
  logic        overflow;

  int n_chk = 0;
  int n_err = 0;
  int act_cnt = 0, nact_cnt = 0, multi_cnt = 0;
  logic [3:0] last_act = '0, last_nact = '0;

  jtag_debug_cmd_queue_if #(.IR_W(2), .DATA_W(38)) cmd_if ();

  jtag_debug_cmd_queue #(
    .IR_W(2), .DATA_W(38), .ACT_BIT(34), .FIFO_DEPTH(4), .SYNC_STAGES(3)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .vs_uir_i         (vs_uir),
    .vs_udr_i         (vs_udr),
    .ir_in_i          (ir_in),
    .sr_i             (sr),
    .ovf_clr_i        (ovf_clr),
    .cmd_if           (cmd_if),
    .jdo_o            (jdo),
    .take_action_o    (ta),
    .take_no_action_o (tna),
    .fifo_count_o     (fifo_count),
    .overflow_o       (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (ta != '0) begin act_cnt++; last_act = ta; end
      if (tna != '0) begin nact_cnt++; last_nact = tna; end
      if ($countones({ta, tna}) > 1) multi_cnt++;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_uir(input logic [1:0] v);
    @(negedge clk); ir_in = v; vs_uir = 1'b1;
    repeat (8) @(negedge clk);
    vs_uir = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_udr(input logic [37:0] d);
    @(negedge clk); sr = d; vs_udr = 1'b1;
    repeat (8) @(negedge clk);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_check(input logic [1:0] exp_ir, input logic [37:0] exp_data);
    logic [3:0] exp_pulse;
    exp_pulse = 4'b0001 << exp_ir;
    @(negedge clk);
    check_val("pop_valid", cmd_if.cmd_valid, 1);
    check_val("pop_ir", cmd_if.cmd_ir, exp_ir);
    check_val("pop_data", cmd_if.cmd_data, exp_data);
    cmd_if.cmd_ready = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ready = 1'b0;
    check_val("pop_jdo", jdo, exp_data);
    check_val("pop_act", ta, exp_data[34] ? exp_pulse : 4'b0000);
    check_val("pop_nact", tna, exp_data[34] ? 4'b0000 : exp_pulse);
    @(negedge clk);
    check_val("pulse_clear", {ta, tna}, 0);
    check_val("jdo_hold", jdo, exp_data);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, n0;
    logic [37:0] d [5];
    logic [37:0] e [5];
    cmd_if.cmd_ready = 1'b0;

    // 1: reset with strobes toggling
    ir_in = 2'd3; sr = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vs_uir = ~vs_uir;
      vs_udr = ~vs_udr;
    end
    @(negedge clk);
    reset = 1'b0; vs_uir = 1'b0; vs_udr = 1'b0;
    check_val("rst_valid", cmd_if.cmd_valid, 0);
    check_val("rst_count", fifo_count, 0);
    check_val("rst_ovf", overflow, 0);
    check_val("rst_jdo", jdo, 0);
    check_val("rst_act", ta, 0);
    check_val("rst_nact", tna, 0);
    repeat (8) @(negedge clk);
    check_val("rst_quiet_valid", cmd_if.cmd_valid, 0);

    // 2: basic action pop with cmd_ready held
    a0 = act_cnt; n0 = nact_cnt;
    cmd_if.cmd_ready = 1'b1;
    pulse_uir(2'd2);
    pulse_udr(38'h4_0000_0ABC);
    cmd_if.cmd_ready = 1'b0;
    check_val("basic_act_cnt", act_cnt - a0, 1);
    check_val("basic_act_val", last_act, 4'b0100);
    check_val("basic_nact_cnt", nact_cnt - n0, 0);
    check_val("basic_jdo", jdo, 38'h4_0000_0ABC);
    check_val("basic_count", fifo_count, 0);

    // 3: latency with 3 sync stages, long strobe
    @(negedge clk); sr = 38'h0_1234_5678; vs_udr = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check_val($sformatf("lat_edge%0d", k), cmd_if.cmd_valid, (k == 5) ? 1 : 0);
    end
    repeat (15) @(negedge clk);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    check_val("lat_count", fifo_count, 1);
    pop_check(2'd2, 38'h0_1234_5678);

    // 4: fill past depth
    d[0] = 38'h0_0000_0011; d[1] = 38'h4_0000_0022; d[2] = 38'h0_AAAA_0033;
    d[3] = 38'h3F_FFFF_FFFF; d[4] = 38'h3_0000_0055;
    for (int i = 0; i < 5; i++) pulse_udr(d[i]);
    check_val("full_count", fifo_count, 4);
    check_val("full_ovf", overflow, 1);
    for (int i = 0; i < 4; i++) pop_check(2'd2, d[i]);
    check_val("drain_count", fifo_count, 0);
    check_val("drain_valid", cmd_if.cmd_valid, 0);
    check_val("ovf_sticky", overflow, 1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    check_val("ovf_cleared", overflow, 0);

    // 5: push and pop on the same edge while full
    e[0] = 38'h0_0000_0101; e[1] = 38'h4_0000_0202; e[2] = 38'h0_0000_0303;
    e[3] = 38'h4_0000_0404; e[4] = 38'h0_0000_0505;
    for (int i = 0; i < 4; i++) pulse_udr(e[i]);
    check_val("simul_pre_count", fifo_count, 4);
    @(negedge clk); sr = e[4]; vs_udr = 1'b1;
    repeat (4) @(negedge clk);
    cmd_if.cmd_ready = 1'b1;
    @(negedge clk);
    cmd_if.cmd_ready = 1'b0;
    check_val("simul_count", fifo_count, 4);
    check_val("simul_ovf", overflow, 0);
    check_val("simul_jdo", jdo, e[0]);
    check_val("simul_nact", tna, 4'b0100);
    repeat (6) @(negedge clk);
    vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    check_val("simul_count_hold", fifo_count, 4);
    for (int i = 1; i < 5; i++) pop_check(2'd2, e[i]);
    check_val("simul_drain", fifo_count, 0);

    // 6: UIR and UDR on the same edge
    pulse_uir(2'd1);
    @(negedge clk); ir_in = 2'd3; sr = 38'h4_0000_0F01; vs_uir = 1'b1; vs_udr = 1'b1;
    repeat (8) @(negedge clk);
    vs_uir = 1'b0; vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    pulse_udr(38'h0_0000_0F02);
    check_val("same_edge_count", fifo_count, 2);
    pop_check(2'd1, 38'h4_0000_0F01);
    pop_check(2'd3, 38'h0_0000_0F02);

    // 7: reset mid-operation discards the queue and the due pulse
    pulse_udr(38'h4_0000_0777);
    check_val("mid_pre_count", fifo_count, 1);
    @(negedge clk); cmd_if.cmd_ready = 1'b1; reset = 1'b1;
    @(negedge clk);
    check_val("mid_pulses", {ta, tna}, 0);
    check_val("mid_count", fifo_count, 0);
    check_val("mid_valid", cmd_if.cmd_valid, 0);
    check_val("mid_jdo", jdo, 0);
    reset = 1'b0; cmd_if.cmd_ready = 1'b0;
    repeat (3) @(negedge clk);

    check_val("onehot_pulses", multi_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
